// File: rtl/pmem_stream_loader.sv
// Rebuilds 12-bit instructions from a framed byte stream and writes them to
// program memory from address 0, flagging done on a verified frame or error on any fault.
module pmem_stream_loader #(
    parameter int PMEM_DEPTH = 10,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [11:0]       o_wr_instr,
    output logic              o_done,
    output logic              o_error,
    output logic [2:0]        o_err_code,
    output logic [ADDR_W-1:0] o_count
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [7:0]       DEPTH_B = 8'(PMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic [7:0]        acc;
    logic [3:0]        hi_nib;
    logic [ADDR_W-1:0] n_words;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              accept;
    logic [ADDR_W-1:0] count_nxt;

    assign accept    = i_rx_valid & o_rx_ready;
    assign count_nxt = o_count + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            hi_nib     <= '0;
            n_words    <= '0;
            tmo_cnt    <= '0;
            o_rx_ready <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_instr <= '0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_err_code <= '0;
            o_count    <= '0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        state      <= S_COUNT;
                        o_rx_ready <= 1'b1;
                        o_count    <= '0;
                        acc        <= '0;
                        tmo_cnt    <= '0;
                        o_done     <= 1'b0;
                        o_error    <= 1'b0;
                        o_err_code <= '0;
                    end
                end
                default: begin
                    // Timeout wins over a byte arriving on the same cycle.
                    if (tmo_cnt >= TMO_MAX) begin
                        state      <= S_ERROR;
                        o_rx_ready <= 1'b0;
                        o_error    <= 1'b1;
                        o_err_code <= 3'd4;
                    end else if (!accept) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= '0;
                        case (state)
                            S_COUNT: begin
                                if (i_rx_data == 8'd0 || i_rx_data > DEPTH_B) begin
                                    state      <= S_ERROR;
                                    o_rx_ready <= 1'b0;
                                    o_error    <= 1'b1;
                                    o_err_code <= 3'd1;
                                end else begin
                                    n_words <= ADDR_W'(i_rx_data);
                                    acc     <= i_rx_data;
                                    state   <= S_HI;
                                end
                            end
                            S_HI: begin
                                if (i_rx_data[7:4] != 4'd0) begin
                                    state      <= S_ERROR;
                                    o_rx_ready <= 1'b0;
                                    o_error    <= 1'b1;
                                    o_err_code <= 3'd2;
                                end else begin
                                    hi_nib <= i_rx_data[3:0];
                                    acc    <= acc ^ i_rx_data;
                                    state  <= S_LO;
                                end
                            end
                            S_LO: begin
                                acc        <= acc ^ i_rx_data;
                                o_wr_en    <= 1'b1;
                                o_wr_addr  <= o_count;
                                o_wr_instr <= {hi_nib, i_rx_data};
                                o_count    <= count_nxt;
                                state      <= (count_nxt == n_words) ? S_CHECK : S_HI;
                            end
                            default: begin
                                o_rx_ready <= 1'b0;
                                if (i_rx_data == acc) begin
                                    state  <= S_DONE;
                                    o_done <= 1'b1;
                                end else begin
                                    state      <= S_ERROR;
                                    o_error    <= 1'b1;
                                    o_err_code <= 3'd3;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_stream_loader.sv
// Directed bench for pmem_stream_loader: one task per scenario, expected values hand-computed.
module tb_pmem_stream_loader;
    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_rx_ready;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [11:0] o_wr_instr;
    logic        o_done;
    logic        o_error;
    logic [2:0]  o_err_code;
    logic [7:0]  o_count;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int wr_n = 0;
    logic [7:0]  la [32];
    logic [11:0] li [32];

    pmem_stream_loader #(.PMEM_DEPTH(10), .ADDR_W(8), .TIMEOUT(1000)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_instr(o_wr_instr),
        .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    // Write log; a strobe held for two cycles shows up as two entries.
    always @(negedge i_clk) begin
        if (o_wr_en) begin
            if (wr_n < 32) begin
                la[wr_n] <= o_wr_addr;
                li[wr_n] <= o_wr_instr;
            end
            wr_n <= wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!o_rx_ready && w < 20) begin
            tick();
            w++;
            stalls++;
        end
        checks++;
        if (o_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte %02h: o_rx_ready=%b after %0d cycles, required 1", b, o_rx_ready, w);
        end else begin
            tick();
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({o_rx_ready, o_wr_en, o_wr_addr, o_wr_instr, o_done, o_error, o_err_code, o_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d instr=%03h done=%b err=%b code=%0d cnt=%0d, required all 0",
                     o_rx_ready, o_wr_en, o_wr_addr, o_wr_instr, o_done, o_error, o_err_code, o_count);
        end
        tick();
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int base, s0;
        base = wr_n;
        pulse_start();
        s0 = stalls;
        send_byte(8'h02); send_byte(8'h0A); send_byte(8'h05);
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'hF1);
        checks++;
        if (stalls !== s0) begin errors++; $display("FAIL nominal_rate: stalls=%0d, required 0", stalls - s0); end
        checks++;
        if (wr_n - base !== 2) begin errors++; $display("FAIL nominal_writes: got %0d, required 2", wr_n - base); end
        checks++;
        if (la[base] !== 8'd0 || li[base] !== 12'hA05) begin
            errors++; $display("FAIL nominal_w0: got addr=%0d instr=%03h, required 0/A05", la[base], li[base]);
        end
        checks++;
        if (la[base+1] !== 8'd1 || li[base+1] !== 12'h3FF) begin
            errors++; $display("FAIL nominal_w1: got addr=%0d instr=%03h, required 1/3FF", la[base+1], li[base+1]);
        end
        checks++;
        if (o_count !== 8'd2 || o_done !== 1'b1 || o_error !== 1'b0 || o_err_code !== 3'd0 || o_rx_ready !== 1'b0) begin
            errors++; $display("FAIL nominal_status: cnt=%0d done=%b err=%b code=%0d rdy=%b, required 2/1/0/0/0",
                               o_count, o_done, o_error, o_err_code, o_rx_ready);
        end
        checks++;
        if (o_wr_en !== 1'b0 || o_wr_addr !== 8'd1 || o_wr_instr !== 12'h3FF) begin
            errors++; $display("FAIL nominal_hold: we=%b addr=%0d instr=%03h, required 0/1/3FF", o_wr_en, o_wr_addr, o_wr_instr);
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h02); send_byte(8'h0A); send_byte(8'h05);
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'hF0);
        checks++;
        if (wr_n - base !== 2) begin errors++; $display("FAIL cksum_writes: got %0d, required 2", wr_n - base); end
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd3 || o_done !== 1'b0) begin
            errors++; $display("FAIL cksum_status: err=%b code=%0d done=%b, required 1/3/0", o_error, o_err_code, o_done);
        end
    endtask

    task automatic test_bad_count_nibble();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h00);
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd1 || o_done !== 1'b0) begin
            errors++; $display("FAIL count_zero: err=%b code=%0d done=%b, required 1/1/0", o_error, o_err_code, o_done);
        end
        pulse_start();
        send_byte(8'h0B);
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd1) begin
            errors++; $display("FAIL count_big: err=%b code=%0d, required 1/1", o_error, o_err_code);
        end
        pulse_start();
        checks++;
        if (o_error !== 1'b0 || o_err_code !== 3'd0) begin
            errors++; $display("FAIL err_clear: err=%b code=%0d, required 0/0", o_error, o_err_code);
        end
        send_byte(8'h01); send_byte(8'h1A);
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd2) begin
            errors++; $display("FAIL bad_nibble: err=%b code=%0d, required 1/2", o_error, o_err_code);
        end
        tick(); tick();
        checks++;
        if (wr_n - base !== 0) begin errors++; $display("FAIL fault_writes: got %0d, required 0", wr_n - base); end
    endtask

    task automatic test_throttle_timeout();
        int s0, w;
        logic [7:0] frame [6];
        frame = '{8'h02, 8'h0A, 8'h05, 8'h03, 8'hFF, 8'hF1};
        pulse_start();
        s0 = stalls;
        for (int i = 0; i < 6; i++) begin
            send_byte(frame[i]);
            tick();
        end
        checks++;
        if (stalls !== s0 || o_done !== 1'b1 || o_count !== 8'd2) begin
            errors++; $display("FAIL throttle: stalls=%0d done=%b cnt=%0d, required 0/1/2", stalls - s0, o_done, o_count);
        end
        pulse_start();
        send_byte(8'h01);
        repeat (990) tick();
        checks++;
        if (o_error !== 1'b0) begin errors++; $display("FAIL timeout_early: err=%b at 990 idle cycles, required 0", o_error); end
        w = 0;
        while (!o_error && w < 30) begin tick(); w++; end
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd4 || o_rx_ready !== 1'b0) begin
            errors++; $display("FAIL timeout: err=%b code=%0d rdy=%b, required 1/4/0", o_error, o_err_code, o_rx_ready);
        end
    endtask

    task automatic test_async_reset();
        int base;
        pulse_start();
        send_byte(8'h02); send_byte(8'h0A);
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_rx_ready, o_wr_en, o_wr_addr, o_wr_instr, o_done, o_error, o_err_code, o_count} !== '0) begin
            errors++; $display("FAIL async_reset: rdy=%b addr=%0d instr=%03h cnt=%0d, required all 0",
                               o_rx_ready, o_wr_addr, o_wr_instr, o_count);
        end
        tick(); tick();
        i_reset_n = 1'b1;
        tick();
        base = wr_n;
        pulse_start();
        send_byte(8'h02); send_byte(8'h0A); send_byte(8'h05);
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'hF1);
        checks++;
        if (wr_n - base !== 2 || li[base] !== 12'hA05 || la[base+1] !== 8'd1 || o_done !== 1'b1) begin
            errors++; $display("FAIL post_reset_load: writes=%0d w0=%03h a1=%0d done=%b, required 2/A05/1/1",
                               wr_n - base, li[base], la[base+1], o_done);
        end
    endtask

    task automatic test_restart();
        int base;
        pulse_start();
        send_byte(8'h02); send_byte(8'h0A);
        pulse_start();
        checks++;
        if (o_rx_ready !== 1'b1 || o_count !== 8'd0 || o_error !== 1'b0) begin
            errors++; $display("FAIL start_in_hi: rdy=%b cnt=%0d err=%b, required 1/0/0", o_rx_ready, o_count, o_error);
        end
        send_byte(8'h05); send_byte(8'h03); send_byte(8'hFF); send_byte(8'hF1);
        checks++;
        if (o_done !== 1'b1 || o_count !== 8'd2) begin
            errors++; $display("FAIL start_ignored: done=%b cnt=%0d, required 1/2", o_done, o_count);
        end
        base = wr_n;
        pulse_start();
        checks++;
        if (o_done !== 1'b0 || o_count !== 8'd0 || o_rx_ready !== 1'b1) begin
            errors++; $display("FAIL restart_clear: done=%b cnt=%0d rdy=%b, required 0/0/1", o_done, o_count, o_rx_ready);
        end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h07); send_byte(8'h06);
        checks++;
        if (wr_n - base !== 1 || la[base] !== 8'd0 || li[base] !== 12'h007 || o_done !== 1'b1 || o_count !== 8'd1) begin
            errors++; $display("FAIL restart_load: writes=%0d addr=%0d instr=%03h done=%b cnt=%0d, required 1/0/007/1/1",
                               wr_n - base, la[base], li[base], o_done, o_count);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_bad_count_nibble();
        test_throttle_timeout();
        test_async_reset();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pmem_stream_loader.md
Name: pmem_stream_loader

Overview:
- Upstream feeder for the microcontroller's program memory load port.
- Accepts a framed byte stream over a valid/ready handshake and rebuilds 12-bit instructions.
- Writes each instruction to consecutive program-memory addresses starting at 0, then raises a done flag. The core uses that flag to leave its LOAD stage.
- Catches framing, content, checksum and timeout faults. On a fault it parks in an error state and never asserts done.

Parameters:
PMEM_DEPTH, 10, number of program-memory words; largest legal instruction count
ADDR_W, 8, width of the write address
TIMEOUT, 1000, idle cycles allowed between accepted bytes while loading before an error is raised

Ports:
i_clk  in  1  clock, rising-edge
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; starts a load from IDLE, DONE or ERROR
i_rx_valid  in  1  byte-stream valid
i_rx_data  in  8  byte-stream data
o_rx_ready  out  1  loader accepts a byte this cycle
o_wr_en  out  1  program-memory load write strobe
o_wr_addr  out  ADDR_W  program-memory load address
o_wr_instr  out  12  instruction written
o_done  out  1  load completed and verified; level signal
o_error  out  1  load aborted; level signal
o_err_code  out  3  0 none, 1 bad count, 2 bad high nibble, 3 checksum mismatch, 4 timeout
o_count  out  ADDR_W  number of instructions written so far in the current load

Behaviour:
- Reset (asynchronous, i_reset_n=0): state IDLE; all outputs 0; checksum accumulator, timeout counter and high-byte latch cleared. Reset mid-load abandons the frame; words already written stay in memory.
- Handshake: a byte is accepted only on a cycle with i_rx_valid=1 and o_rx_ready=1.
  - o_rx_ready=1 only in COUNT, HI, LO and CHECK.
  - o_rx_ready is registered and depends only on state.
- Frame format: count byte N, then N pairs {HI, LO}, then checksum byte.
  - HI[3:0] = instr[11:8]; HI[7:4] must be 0.
  - LO = instr[7:0].
  - Checksum = XOR of N and every HI and LO byte.
- States:
  - IDLE: on i_start, clear o_count, accumulator, o_done, o_error and o_err_code; go to COUNT.
  - COUNT: on an accepted byte, if N=0 or N>PMEM_DEPTH go to ERROR with code 1. Otherwise store N, set acc=N, go to HI.
  - HI: on an accepted byte, if bits [7:4]≠0 go to ERROR with code 2. Otherwise latch the nibble, XOR the byte into acc, go to LO.
  - LO: on an accepted byte, XOR it into acc and register the write.
    - Next cycle: o_wr_en=1 for exactly one cycle, with o_wr_addr=o_count (value before increment) and o_wr_instr={nibble, byte}. o_count increments on that same cycle.
    - Go to CHECK if this was pair N, else to HI.
  - CHECK: on an accepted byte, if byte=acc go to DONE, else go to ERROR with code 3.
  - DONE: o_done=1 (asserted the cycle after checksum acceptance). i_start restarts the load as from IDLE.
  - ERROR: o_error=1 and o_err_code held. i_start restarts the load as from IDLE.
- Write latency: one cycle from LO acceptance to o_wr_en. Back-to-back pairs must be accepted at the full rate of 1 byte/cycle.
- Timeout: in COUNT, HI, LO and CHECK, the counter increments every cycle without an accepted byte and clears on acceptance. Reaching TIMEOUT goes to ERROR with code 4, checked before the byte on the same cycle.
- i_start during COUNT, HI, LO or CHECK is ignored.
- Addresses never wrap: the count check bounds o_wr_addr to PMEM_DEPTH-1.
- o_wr_addr and o_wr_instr hold their last values when o_wr_en=0.

Test Plan:
- Nominal load: i_start, then bytes 02,0A,05,03,FF,F1 at one per cycle → writes addr0=0xA05 and addr1=0x3FF, each with a single-cycle o_wr_en; o_count=2; o_done=1; o_err_code=0.
- Bad checksum: same frame with last byte F0 → both writes occur, then o_error=1, o_err_code=3, o_done=0.
- Bad count and bad nibble:
  - Count byte 00 → ERROR code 1 with no writes.
  - Count byte 0B (with PMEM_DEPTH=10) → ERROR code 1.
  - Frame 01,1A,… → ERROR code 2 after the HI byte, with no writes.
- Timeout and throttling: valid toggled 1/0 on alternate cycles → all bytes accepted; then hold valid=0 for 1000 cycles in HI → o_error=1, o_err_code=4.
- Async reset mid-frame: drop i_reset_n between the HI and LO bytes → all outputs 0 immediately, with no clock edge needed; a following i_start plus a nominal frame loads correctly.
- Restart: i_start pulsed while in HI → ignored; i_start in DONE → flags clear and a new 1-word frame 01,00,07,06 gives addr0=0x007 and o_done=1.
